// File: rtl/if_id_skid_reg.sv
// Elastic IF/ID stage: valid/ready handshake, 2-entry skid buffer, synchronous flush.
// Define IF_ID_PERF_CNT_EN to build the saturating fetch back-pressure counter on STALL_CNT.
module if_id_skid_reg #(
    parameter int unsigned             ADR_W       = 32,
    parameter int unsigned             INS_W       = 32,
    parameter logic [INS_W-1:0]        NOP_INS     = '0,
    parameter int unsigned             STALL_CNT_W = 16
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   FLUSH,
    input  logic                   IN_VALID,
    output logic                   IN_READY,
    input  logic [ADR_W-1:0]       NEXT_INS_ADR_IN,
    input  logic [INS_W-1:0]       CUR_INS_IN,
    output logic                   OUT_VALID,
    input  logic                   OUT_READY,
    output logic [ADR_W-1:0]       NEXT_INS_ADR_OUT,
    output logic [INS_W-1:0]       CUR_INS_OUT,
    output logic [STALL_CNT_W-1:0] STALL_CNT
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [ADR_W-1:0] skid_adr;
    logic [INS_W-1:0] skid_ins;
    logic             in_fire;
    logic             out_fire;
    logic             load_main_in;
    logic             load_main_skid;
    logic             load_skid;

    always_ff @(posedge CLK) begin
        if (RST || FLUSH) begin
            state <= EMPTY;
        end else begin
            state <= state_n;
        end
    end

    // Valid/ready decode from the state register only, so no input reaches these outputs combinationally.
    always_comb begin
        state_n        = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        OUT_VALID      = (state != EMPTY);
        IN_READY       = (state != FULL);
        in_fire        = IN_VALID & IN_READY;
        out_fire       = OUT_VALID & OUT_READY;
        case (state)
            EMPTY: begin
                if (in_fire) begin
                    state_n      = HALF;
                    load_main_in = 1'b1;
                end
            end
            HALF: begin
                if (in_fire && out_fire) begin
                    load_main_in = 1'b1;
                end else if (in_fire) begin
                    state_n   = FULL;
                    load_skid = 1'b1;
                end else if (out_fire) begin
                    state_n = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    state_n        = HALF;
                    load_main_skid = 1'b1;
                end
            end
            default: state_n = EMPTY;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST || FLUSH) begin
            NEXT_INS_ADR_OUT <= '0;
            CUR_INS_OUT      <= NOP_INS;
        end else if (load_main_in) begin
            NEXT_INS_ADR_OUT <= NEXT_INS_ADR_IN;
            CUR_INS_OUT      <= CUR_INS_IN;
        end else if (load_main_skid) begin
            NEXT_INS_ADR_OUT <= skid_adr;
            CUR_INS_OUT      <= skid_ins;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            skid_adr <= '0;
            skid_ins <= NOP_INS;
        end else if (load_skid && !FLUSH) begin
            skid_adr <= NEXT_INS_ADR_IN;
            skid_ins <= CUR_INS_IN;
        end
    end

`ifdef IF_ID_PERF_CNT_EN
    // Saturates instead of wrapping; FLUSH deliberately leaves the count alone.
    always_ff @(posedge CLK) begin
        if (RST) begin
            STALL_CNT <= '0;
        end else if (IN_VALID && !IN_READY && !FLUSH && (STALL_CNT != '1)) begin
            STALL_CNT <= STALL_CNT + 1'b1;
        end
    end
`else
    assign STALL_CNT = '0;
`endif

endmodule
